// File: rtl/word_stream_if.sv
// word_stream_if: valid/ready letter stream from the generator to a consumer.
interface word_stream_if;
    logic [7:0] letter;
    logic       valid;
    logic       ready;
    logic       in_word;
    logic       word_end;
    logic [7:0] word_cnt;
    modport master (output letter, valid, in_word, word_end, word_cnt, input ready);
    modport slave (input letter, valid, in_word, word_end, word_cnt, output ready);
endinterface

// File: rtl/word_stream_gen.sv
// word_stream_gen: LFSR filler letters with on-demand contiguous insertion of WORD.
module word_stream_gen #(
    parameter int                  WORD_LEN = 6,
    parameter logic [8*WORD_LEN-1:0] WORD   = "ABSENT",
    parameter logic [15:0]         SEED     = 16'hACE1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           inject,
    word_stream_if.master  s
);
    typedef enum logic [1:0] {IDLE, FILL, SEND} state_t;
    localparam logic [7:0] FIRST = WORD[8*WORD_LEN-1 -: 8];
    state_t                state, state_n;
    logic [15:0]           lfsr, lfsr_n;
    logic [4:0]            idx, idx_n, v;
    logic [7:0]            letter_n, cnt_n, raw, fill, wchar;
    logic [8*WORD_LEN-1:0] word_sh;
    logic                  pending, word_end_n, load_w0, acc;
    assign s.valid   = state != IDLE;
    assign s.in_word = state == SEND;
    assign acc       = s.valid && s.ready;
    assign word_sh   = WORD << {idx, 3'b000};
    assign wchar     = word_sh[8*WORD_LEN-1 -: 8];
    assign v         = lfsr[4:0] >= 5'd26 ? lfsr[4:0] - 5'd26 : lfsr[4:0];
    assign raw       = 8'h41 + {3'b000, v};
    // Filler never starts the target word, so WORD only appears where injected
    assign fill      = raw != FIRST ? raw : (raw == 8'h5A ? 8'h41 : raw + 8'd1);
    always_comb begin
        state_n    = state;
        letter_n   = s.letter;
        idx_n      = idx;
        lfsr_n     = lfsr;
        word_end_n = 1'b0;
        cnt_n      = s.word_cnt;
        load_w0    = 1'b0;
        if (acc && state == SEND && int'(idx) < WORD_LEN) begin
            letter_n = wchar;
            idx_n    = idx + 5'd1;
        end else if (state == IDLE ? en : acc) begin
            if (state == SEND) begin
                word_end_n = 1'b1;
                cnt_n      = s.word_cnt + 8'd1;
            end
            if (!en) begin
                state_n = IDLE;
            end else if (pending) begin
                load_w0  = 1'b1;
                letter_n = FIRST;
                idx_n    = 5'd1;
                state_n  = SEND;
            end else begin
                letter_n = fill;
                lfsr_n   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                state_n  = FILL;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= SEED;
            idx        <= 5'd0;
            pending    <= 1'b0;
            s.letter   <= 8'h00;
            s.word_end <= 1'b0;
            s.word_cnt <= 8'h00;
        end else begin
            state      <= state_n;
            lfsr       <= lfsr_n;
            idx        <= idx_n;
            pending    <= inject | (pending & ~load_w0);
            s.letter   <= letter_n;
            s.word_end <= word_end_n;
            s.word_cnt <= cnt_n;
        end
    end
endmodule

// File: doc/word_stream_gen.md
Name: word_stream_gen

Overview:
- Source of ASCII letter streams for exercising the word-detector block.
- Emits one uppercase letter per accepted beat on a valid/ready interface.
- Between requests it emits pseudo-random filler letters from an LFSR.
- On an inject request it emits the target word WORD contiguously, so a downstream detector receives a known word at a known position within random letters.

Parameters:
- WORD_LEN, 6: number of characters in the target word (1..16).
- WORD, "ABSENT": target word, 8*WORD_LEN bits; first character in the most significant byte.
- SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk, input, 1: clock; all state changes on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: stream enable.
- inject, input, 1: request one insertion of WORD; may be a single-cycle pulse.
- ready, input, 1: consumer accepts the current letter.
- letter, output, 8: ASCII letter.
- valid, output, 1: letter is valid.
- in_word, output, 1: the current letter belongs to WORD.
- word_end, output, 1: one-cycle pulse after the last WORD character is accepted.
- word_cnt, output, 8: number of completed words, wraps 255 to 0.

Behaviour:
- Reset (asynchronous, active-high): letter=8'h00, valid=0, in_word=0, word_end=0, word_cnt=0, lfsr=SEED, pending=0, idx=0, state=IDLE.
- Beat acceptance: a beat is accepted when valid && ready.
- Holding: while valid && !ready, letter and in_word hold stable and no state changes, except that pending may be set.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11, shifting left. The new bit 0 is lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10].
- Filler letter: v = lfsr[4:0], minus 26 if v >= 26; letter = 8'h41 + v.
  - If the result equals the first character of WORD, use the next letter instead (Z wraps to A).
  - The lfsr steps once each time a filler letter is loaded onto letter.
- pending: set by inject in any state, including during reset release; cleared when WORD[0] is loaded. Multiple inject pulses before the load collapse into one word.
- States:
  - IDLE (valid=0): if en, load the next letter and go to FILL, or to WORD if pending. The first beat is valid the cycle after en is sampled high.
  - FILL (valid=1, in_word=0): on an accepted beat:
    - if !en, go to IDLE and drop valid;
    - else if pending, load WORD[0], set idx=1 and go to WORD;
    - else load the next filler letter.
  - WORD (valid=1, in_word=1): on an accepted beat:
    - if idx < WORD_LEN, load WORD[idx] and increment idx;
    - otherwise, in the next cycle pulse word_end for one cycle and increment word_cnt, then continue per the FILL rules (IDLE if !en, a new word if pending, else filler).
- en is ignored inside WORD: a word is never truncated, and deasserting en takes effect after the word completes.
- Back-to-back operation: with ready held high, one letter is output per cycle and there are no bubbles between filler and word, or between consecutive words.
- Reset mid-word: the partial word is abandoned, word_cnt is not incremented, and the block returns to IDLE immediately.
- WORD_LEN=1: WORD state lasts one beat, and word_end follows that beat.
- Accidental occurrences of WORD in filler are prevented only at the first character. Overlap cases inherent to WORD's self-similarity are out of scope.

Test Plan:
- Reset with SEED=16'hACE1, then en=1 and ready=1 -> valid rises one cycle after en is sampled; the first letter is 8'h42 ('B', lfsr[4:0]=1). Each later letter is in 8'h41..8'h5A and never 'A'.
- inject pulse during FILL with ready=1 -> the next six letters are 41,42,53,45,4E,54 with in_word=1. word_end is high for one cycle after 8'h54 is accepted, word_cnt=1, then filler resumes.
- ready toggled 1010... during a word -> letter is stable while ready=0, the word is still emitted complete and in order, and the total beat count is unchanged.
- en dropped at word character 3 -> the remaining characters are emitted, word_end pulses, then valid=0. With en dropped during FILL, valid=0 after the next accepted beat.
- Two inject pulses during one word -> exactly one further word follows immediately with no filler between. Three pulses before a load -> one word only.
- rst asserted asynchronously at word character 4 -> all outputs are zero without waiting for a clock edge and word_cnt stays at its previous value (0 after reset). After reset release, the first filler letter is 8'h42 again.
